regfile_mp: RTL and testbench

Parametrised multi-port ARM register file for the pipelined core's decode stage. It provides NRD combinational read ports and two rising-edge write ports (result writeback and base-register writeback), with same-cycle write-to-read bypass. A per-register pending scoreboard flags reads of registers that an in-flight instruction has reserved but not yet written. Index NREGS-1 is the PC: reads return the supplied PC+8, and writes and reservations to it are ignored.

---
 rtl/regfile_mp.sv | 152 +++++++++++++++
 tb/tb_regfile_mp.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//
// Multi-port ARM register file for the decode stage of the pipelined core.
//   * NRD combinational read ports with same-cycle write-to-read bypass.
//   * Two rising-edge write ports: port 0 (result writeback) and port 1 (base
//     writeback). Port 0 wins when both target the same register.
//   * Index NREGS-1 is the PC. It has no storage. Reads of it return pc_plus8,
//     and writes or reservations to it are ignored.
//   * Per-register pending scoreboard. A reservation from a multi-cycle
//     producer sets the bit, and a writeback to the register clears it. When
//     both happen on the same edge, the reservation wins because it belongs to
//     a newer instruction. pend_cnt is the registered population count.
//
// Ports
//   clk        in   1        clock, rising edge
//   reset      in   1        asynchronous active-high reset
//   we0/wa0/wd0 in  1/AW/DW  write port 0 (result writeback)
//   we1/wa1/wd1 in  1/AW/DW  write port 1 (base writeback)
//   ra         in   NRD*AW   read addresses, port i at [i*AW +: AW]
//   rd         out  NRD*DW   read data, port i at [i*DW +: DW]
//   busy       out  NRD      port i reads a pending register not written now
//   pc_plus8   in   DW       value returned for reads of the PC index
//   rsv_valid  in   1        reserve rsv_addr as a pending destination
//   rsv_addr   in   AW       register to reserve
//   pend_cnt   out  AW+1     number of pending registers
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter  int DW    = 32,
    parameter  int NREGS = 16,
    parameter  int NRD   = 3,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [DW-1:0]     wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [DW-1:0]     wd1,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*DW-1:0] rd,
    output logic [NRD-1:0]    busy,
    input  logic [DW-1:0]     pc_plus8,
    input  logic              rsv_valid,
    input  logic [AW-1:0]     rsv_addr,
    output logic [AW:0]       pend_cnt
);

    localparam int            NPHY   = NREGS - 1;
    localparam logic [AW-1:0] PC_IDX = AW'(NREGS - 1);

    logic [DW-1:0]   rf_q [NPHY];
    logic [DW-1:0]   rf_d [NPHY];
    logic [NPHY-1:0] pend_q, pend_d;
    logic [AW:0]     pend_cnt_q, pend_cnt_d;

    logic wr0_ok, wr1_ok;

    // A PC-targeted write is dropped entirely. Port 1 is also dropped when
    // port 0 commits to the same register on the same edge.
    assign wr0_ok = we0 && (wa0 != PC_IDX);
    assign wr1_ok = we1 && (wa1 != PC_IDX) && !(wr0_ok && (wa0 == wa1));

    // -------------------------------------------------------------------------
    // Storage next state
    // -------------------------------------------------------------------------
    always_comb begin
        for (int j = 0; j < NPHY; j++) begin
            rf_d[j] = rf_q[j];
            if (wr0_ok && (wa0 == AW'(j))) begin
                rf_d[j] = wd0;
            end else if (wr1_ok && (wa1 == AW'(j))) begin
                rf_d[j] = wd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pending scoreboard next state and population count
    // -------------------------------------------------------------------------
    always_comb begin
        pend_d     = pend_q;
        pend_cnt_d = '0;
        for (int j = 0; j < NPHY; j++) begin
            // Any enabled write to the register retires its reservation,
            // including a port-1 write that port 0 overrides.
            if ((we0 && (wa0 == AW'(j))) || (we1 && (wa1 == AW'(j)))) begin
                pend_d[j] = 1'b0;
            end
            // A new reservation overrides a same-edge clear.
            if (rsv_valid && (rsv_addr == AW'(j))) begin
                pend_d[j] = 1'b1;
            end
            pend_cnt_d = pend_cnt_d + {{AW{1'b0}}, pend_d[j]};
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < NPHY; j++) begin
                rf_q[j] <= '0;
            end
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            for (int j = 0; j < NPHY; j++) begin
                rf_q[j] <= rf_d[j];
            end
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend_cnt = pend_cnt_q;

    // -------------------------------------------------------------------------
    // Read ports: PC first, then port-0 bypass, then port-1 bypass, then storage
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] addr;
        logic          is_pc;
        logic          hit0;
        logic          hit1;
        logic [DW-1:0] stored;
        logic          pend_bit;

        assign addr  = ra[g*AW +: AW];
        assign is_pc = (addr == PC_IDX);
        assign hit0  = we0 && (wa0 == addr);
        assign hit1  = we1 && (wa1 == addr);

        // Storage and scoreboard lookups are only consulted for non-PC
        // addresses. Forcing zero here keeps the PC index from selecting a
        // nonexistent entry.
        assign stored   = is_pc ? '0   : rf_q[addr];
        assign pend_bit = is_pc ? 1'b0 : pend_q[addr];

        assign rd[g*DW +: DW] = is_pc ? pc_plus8 :
                                hit0  ? wd0      :
                                hit1  ? wd1      : stored;

        // A write landing this cycle already supplies the value through
        // bypass, so the register no longer needs to stall the reader.
        assign busy[g] = pend_bit && !(hit0 || hit1);
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int NREGS = 16;
    localparam int NRD   = 3;
    localparam int AW    = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              we0, we1;
    logic [AW-1:0]     wa0, wa1;
    logic [DW-1:0]     wd0, wd1;
    logic [NRD*AW-1:0] ra;
    logic [NRD*DW-1:0] rd;
    logic [NRD-1:0]    busy;
    logic [DW-1:0]     pc_plus8;
    logic              rsv_valid;
    logic [AW-1:0]     rsv_addr;
    logic [AW:0]       pend_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural contents and the set of pending registers.
    logic [DW-1:0]    m_rf [NREGS];
    logic [NREGS-1:0] m_pend;

    regfile_mp #(.DW(DW), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk       (clk),
        .reset     (reset),
        .we0       (we0),
        .wa0       (wa0),
        .wd0       (wd0),
        .we1       (we1),
        .wa1       (wa1),
        .wd1       (wd1),
        .ra        (ra),
        .rd        (rd),
        .busy      (busy),
        .pc_plus8  (pc_plus8),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .pend_cnt  (pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == AW'(NREGS - 1))  return pc_plus8;
        if (we0 && wa0 == a)      return wd0;
        if (we1 && wa1 == a)      return wd1;
        return m_rf[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == AW'(NREGS - 1)) return 1'b0;
        return m_pend[a] && !((we0 && wa0 == a) || (we1 && wa1 == a));
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) m_rf[r] = '0;
        m_pend = '0;
    endtask

    task automatic model_commit();
        logic [AW-1:0] pc;
        pc = AW'(NREGS - 1);
        if (we1 && wa1 != pc && !(we0 && wa0 == wa1)) m_rf[wa1] = wd1;
        if (we0 && wa0 != pc)                         m_rf[wa0] = wd0;
        if (we0 && wa0 != pc) m_pend[wa0] = 1'b0;
        if (we1 && wa1 != pc) m_pend[wa1] = 1'b0;
        if (rsv_valid && rsv_addr != pc) m_pend[rsv_addr] = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        logic [AW-1:0] a;
        for (int i = 0; i < NRD; i++) begin
            a = ra[i*AW +: AW];
            chk($sformatf("%s_rd%0d_a%0d", tag, i, a), {32'h0, rd[i*DW +: DW]}, {32'h0, exp_rd(a)});
            chk($sformatf("%s_busy%0d_a%0d", tag, i, a), 64'(busy[i]), 64'(exp_busy(a)));
        end
        chk($sformatf("%s_pend_cnt", tag), 64'(pend_cnt), 64'($countones(m_pend)));
    endtask

    // Check the combinational view, then clock once and advance the model.
    task automatic cycle(input string tag);
        #1;
        check_outputs(tag);
        @(posedge clk);
        if (reset) model_reset();
        else       model_commit();
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        rsv_valid = 1'b0; rsv_addr = '0;
    endtask

    task automatic set_ra(input int a0, input int a1, input int a2);
        ra = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    initial begin
        // Reset while writes and a reservation are presented.
        reset = 1'b1;
        pc_plus8 = 32'h0000_0108;
        we0 = 1'b1; wa0 = 4'd3; wd0 = 32'h1234_5678;
        we1 = 1'b1; wa1 = 4'd4; wd1 = 32'h8765_4321;
        rsv_valid = 1'b1; rsv_addr = 4'd6;
        ra = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle();
        reset = 1'b0;

        for (int a = 0; a < NREGS; a += 3) begin
            set_ra(a, (a + 1) % NREGS, (a + 2) % NREGS);
            #1;
            check_outputs("rst_read");
        end
        set_ra(15, 0, 14);
        #1;
        chk("rst_pc_read", 64'(rd[31:0]), 64'h108);
        chk("rst_r0", 64'(rd[63:32]), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_cnt", 64'(pend_cnt), 64'h0);
        @(posedge clk);
        #1;

        // Write with same-cycle bypass, then from storage.
        we0 = 1'b1; wa0 = 4'd3; wd0 = 32'hDEAD_BEEF;
        set_ra(3, 3, 3);
        #1;
        chk("wr3_bypass", 64'(rd[31:0]), 64'hDEAD_BEEF);
        cycle("wr3");
        idle();
        #1;
        chk("wr3_stored", 64'(rd[31:0]), 64'hDEAD_BEEF);
        cycle("rd3");

        // Both ports to r5: port 0 wins.
        we0 = 1'b1; wa0 = 4'd5; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 4'd5; wd1 = 32'h22;
        set_ra(5, 5, 5);
        #1;
        chk("dual_bypass", 64'(rd[95:64]), 64'h11);
        cycle("dual");
        idle();
        #1;
        chk("dual_stored", 64'(rd[31:0]), 64'h11);
        cycle("dual_after");

        // Write to PC index is ignored.
        we0 = 1'b1; wa0 = 4'd15; wd0 = 32'h55;
        set_ra(15, 5, 3);
        #1;
        chk("pc_wr_read", 64'(rd[31:0]), 64'h108);
        cycle("pc_wr");
        idle();
        #1;
        chk("pc_wr_after", 64'(rd[31:0]), 64'h108);
        chk("pc_wr_r5", 64'(rd[63:32]), 64'h11);
        cycle("pc_wr_idle");

        // Reserve r7, then retire it with a port-0 write.
        rsv_valid = 1'b1; rsv_addr = 4'd7;
        set_ra(7, 7, 7);
        #1;
        chk("rsv7_n_busy", 64'(busy), 64'h0);
        cycle("rsv7_n");
        idle();
        #1;
        chk("rsv7_n1_busy", 64'(busy), 64'h7);
        chk("rsv7_n1_cnt", 64'(pend_cnt), 64'h1);
        cycle("rsv7_n1");
        cycle("rsv7_n2");
        we0 = 1'b1; wa0 = 4'd7; wd0 = 32'hCAFE_0007;
        #1;
        chk("rsv7_n3_busy", 64'(busy), 64'h0);
        chk("rsv7_n3_rd", 64'(rd[31:0]), 64'hCAFE_0007);
        chk("rsv7_n3_cnt", 64'(pend_cnt), 64'h1);
        cycle("rsv7_n3");
        idle();
        #1;
        chk("rsv7_n4_cnt", 64'(pend_cnt), 64'h0);
        chk("rsv7_n4_busy", 64'(busy), 64'h0);
        cycle("rsv7_n4");

        // Same-edge reserve and port-1 write of r2: reservation survives.
        rsv_valid = 1'b1; rsv_addr = 4'd2;
        we1 = 1'b1; wa1 = 4'd2; wd1 = 32'hA5A5_0002;
        set_ra(2, 2, 2);
        cycle("setclr2");
        idle();
        #1;
        chk("setclr2_busy", 64'(busy), 64'h7);
        chk("setclr2_cnt", 64'(pend_cnt), 64'h1);
        chk("setclr2_rd", 64'(rd[31:0]), 64'hA5A5_0002);
        rsv_valid = 1'b1; rsv_addr = 4'd15;
        cycle("rsv15");
        idle();
        #1;
        chk("rsv15_cnt", 64'(pend_cnt), 64'h1);
        we0 = 1'b1; wa0 = 4'd2; wd0 = 32'h0000_0222;
        cycle("clr2");
        idle();

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            we0 = ($urandom_range(0, 2) == 0);
            wa0 = AW'($urandom_range(0, 15));
            wd0 = $urandom;
            we1 = ($urandom_range(0, 3) == 0);
            wa1 = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom_range(0, 15));
            wd1 = $urandom;
            rsv_valid = ($urandom_range(0, 2) == 0);
            rsv_addr = ($urandom_range(0, 4) == 0) ? wa0 : AW'($urandom_range(0, 15));
            pc_plus8 = $urandom;
            set_ra($urandom_range(0, 15), $urandom_range(0, 15),
                   ($urandom_range(0, 3) == 0) ? int'(rsv_addr) : $urandom_range(0, 15));
            cycle("rnd");
        end
        idle();
        pc_plus8 = 32'h0000_0108;

        // Fill the scoreboard, then reset asynchronously between edges.
        for (int r = 0; r < NREGS - 1; r++) begin
            rsv_valid = 1'b1; rsv_addr = AW'(r);
            cycle("fill");
        end
        idle();
        set_ra(0, 7, 14);
        #1;
        chk("fill_cnt", 64'(pend_cnt), 64'd15);
        chk("fill_busy", 64'(busy), 64'h7);
        reset = 1'b1;
        #1;
        chk("arst_cnt", 64'(pend_cnt), 64'h0);
        chk("arst_busy", 64'(busy), 64'h0);
        model_reset();
        check_outputs("arst");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
